// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - request/response and RAM pin bundle for mem_arbiter
// Purpose: groups the IF port, the LSU port and the byte-wide RAM pins.
// Ports (signals):
//   IF  : if_valid_in, if_addr_in[31:0] -> if_done_out, if_data_out[31:0]
//   LSU : lsu_valid_in, lsu_wr_in, lsu_size_in[1:0], lsu_addr_in[31:0],
//         lsu_wdata_in[31:0] -> lsu_done_out, lsu_rdata_out[31:0]
//   RAM : ram_en_out, ram_r_nw_out, ram_a_out, ram_d_out[7:0] <- ram_d_in[7:0]
// Modports: slave = arbiter side, master = core/RAM side.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 17
);
    logic                  if_valid_in;
    logic [31:0]           if_addr_in;
    logic                  if_done_out;
    logic [31:0]           if_data_out;
    logic                  lsu_valid_in;
    logic                  lsu_wr_in;
    logic [1:0]            lsu_size_in;
    logic [31:0]           lsu_addr_in;
    logic [31:0]           lsu_wdata_in;
    logic                  lsu_done_out;
    logic [31:0]           lsu_rdata_out;
    logic                  ram_en_out;
    logic                  ram_r_nw_out;
    logic [ADDR_WIDTH-1:0] ram_a_out;
    logic [7:0]            ram_d_out;
    logic [7:0]            ram_d_in;

    modport slave (
        input  if_valid_in, if_addr_in,
        input  lsu_valid_in, lsu_wr_in, lsu_size_in, lsu_addr_in, lsu_wdata_in,
        input  ram_d_in,
        output if_done_out, if_data_out, lsu_done_out, lsu_rdata_out,
        output ram_en_out, ram_r_nw_out, ram_a_out, ram_d_out
    );

    modport master (
        output if_valid_in, if_addr_in,
        output lsu_valid_in, lsu_wr_in, lsu_size_in, lsu_addr_in, lsu_wdata_in,
        output ram_d_in,
        input  if_done_out, if_data_out, lsu_done_out, lsu_rdata_out,
        input  ram_en_out, ram_r_nw_out, ram_a_out, ram_d_out
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - byte-wide single-port RAM sequencer shared by IF and LSU
// Purpose: arbitrates IF/LSU requests round-robin and splits each 1/2/4-byte
//          little-endian access into single-byte RAM cycles.
// Ports:
//   clk_in   : system clock, rising edge
//   rst_n_in : asynchronous active-low reset
//   bus      : mem_arbiter_if.slave (IF, LSU and RAM pin groups)
module mem_arbiter #(
    parameter int ADDR_WIDTH = 17
) (
    input  logic          clk_in,
    input  logic          rst_n_in,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    state_t                r_state;
    logic                  r_owner_lsu;
    logic                  r_prio_lsu;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [2:0]            r_n;
    logic                  r_wr;
    logic [31:0]           r_wdata;
    logic [2:0]            r_cnt;      // index of the upcoming edge relative to E0
    logic [31:0]           r_buf;
    logic                  r_ram_en;
    logic                  r_ram_rnw;
    logic [ADDR_WIDTH-1:0] r_ram_a;
    logic [7:0]            r_ram_d;
    logic                  r_if_done;
    logic                  r_lsu_done;
    logic [31:0]           r_if_data;
    logic [31:0]           r_lsu_rdata;

    logic                  w_grant_lsu;
    logic [2:0]            w_lsu_n;
    logic [31:0]           w_cap;
    logic [7:0]            w_wbyte;
    logic [ADDR_WIDTH-1:0] w_next_a;
    logic                  w_unused_addr_hi;

    assign w_unused_addr_hi = ^{bus.if_addr_in[31:ADDR_WIDTH], bus.lsu_addr_in[31:ADDR_WIDTH]};

    // Without contention the lone requester wins; with contention r_prio_lsu picks.
    assign w_grant_lsu = bus.lsu_valid_in & (~bus.if_valid_in | r_prio_lsu);
    assign w_lsu_n     = (bus.lsu_size_in == 2'b00) ? 3'd1 :
                         (bus.lsu_size_in == 2'b01) ? 3'd2 : 3'd4;
    assign w_next_a    = r_addr + ADDR_WIDTH'(r_cnt);

    // RAM data sampled at edge k belongs to byte k-2 (synchronous read latency).
    assign w_cap = {24'd0, bus.ram_d_in} << {r_cnt - 3'd2, 3'b000};

    always_comb begin
        w_wbyte = r_wdata[7:0];
        case (r_cnt[1:0])
            2'd1:    w_wbyte = r_wdata[15:8];
            2'd2:    w_wbyte = r_wdata[23:16];
            2'd3:    w_wbyte = r_wdata[31:24];
            default: w_wbyte = r_wdata[7:0];
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state     <= S_IDLE;
            r_owner_lsu <= 1'b0;
            r_prio_lsu  <= 1'b1;
            r_addr      <= '0;
            r_n         <= 3'd0;
            r_wr        <= 1'b0;
            r_wdata     <= 32'd0;
            r_cnt       <= 3'd0;
            r_buf       <= 32'd0;
            r_ram_en    <= 1'b0;
            r_ram_rnw   <= 1'b1;
            r_ram_a     <= '0;
            r_ram_d     <= 8'd0;
            r_if_done   <= 1'b0;
            r_lsu_done  <= 1'b0;
            r_if_data   <= 32'd0;
            r_lsu_rdata <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.lsu_valid_in || bus.if_valid_in) begin
                        r_owner_lsu <= w_grant_lsu;
                        r_prio_lsu  <= ~w_grant_lsu;
                        r_addr      <= w_grant_lsu ? bus.lsu_addr_in[ADDR_WIDTH-1:0]
                                                   : bus.if_addr_in[ADDR_WIDTH-1:0];
                        r_n         <= w_grant_lsu ? w_lsu_n : 3'd4;
                        r_wr        <= w_grant_lsu & bus.lsu_wr_in;
                        r_wdata     <= bus.lsu_wdata_in;
                        r_cnt       <= 3'd1;
                        r_buf       <= 32'd0;
                        // Byte 0 is presented straight after the grant edge.
                        r_ram_en    <= 1'b1;
                        r_ram_rnw   <= ~(w_grant_lsu & bus.lsu_wr_in);
                        r_ram_a     <= w_grant_lsu ? bus.lsu_addr_in[ADDR_WIDTH-1:0]
                                                   : bus.if_addr_in[ADDR_WIDTH-1:0];
                        r_ram_d     <= (w_grant_lsu & bus.lsu_wr_in) ? bus.lsu_wdata_in[7:0] : 8'd0;
                        r_state     <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    r_cnt <= r_cnt + 3'd1;
                    if (!r_wr && r_cnt >= 3'd2) begin
                        r_buf <= r_buf | w_cap;
                    end
                    if (r_cnt < r_n) begin
                        r_ram_a <= w_next_a;
                        r_ram_d <= r_wr ? w_wbyte : 8'd0;
                    end else if (r_wr || r_cnt == r_n + 3'd1) begin
                        r_ram_en   <= 1'b0;
                        r_ram_rnw  <= 1'b1;
                        r_ram_a    <= '0;
                        r_ram_d    <= 8'd0;
                        r_if_done  <= ~r_owner_lsu;
                        r_lsu_done <= r_owner_lsu;
                        if (!r_wr) begin
                            if (r_owner_lsu) r_lsu_rdata <= r_buf | w_cap;
                            else             r_if_data   <= r_buf | w_cap;
                        end
                        r_state <= S_DONE;
                    end
                    // Otherwise: trailing read cycle, RAM pins held so the last byte stays driven.
                end
                default: begin
                    r_if_done  <= 1'b0;
                    r_lsu_done <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.if_done_out   = r_if_done;
    assign bus.if_data_out   = r_if_data;
    assign bus.lsu_done_out  = r_lsu_done;
    assign bus.lsu_rdata_out = r_lsu_rdata;
    assign bus.ram_en_out    = r_ram_en;
    assign bus.ram_r_nw_out  = r_ram_rnw;
    assign bus.ram_a_out     = r_ram_a;
    assign bus.ram_d_out     = r_ram_d;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_WIDTH(17)) bus();
    mem_arbiter #(.ADDR_WIDTH(17)) dut (.clk_in(clk), .rst_n_in(rst_n), .bus(bus));

    logic [7:0] mem [0:131071];
    logic [7:0] rd_q;
    int         cyc = 0;
    logic [16:0] wa [$];
    logic [7:0]  wd [$];
    int          wc [$];

    // Synchronous-read RAM whose output is gated by the current enable.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.ram_en_out) begin
            if (bus.ram_r_nw_out) rd_q <= mem[bus.ram_a_out];
            else begin
                mem[bus.ram_a_out] = bus.ram_d_out;
                wa.push_back(bus.ram_a_out);
                wd.push_back(bus.ram_d_out);
                wc.push_back(cyc);
            end
        end
    end
    assign bus.ram_d_in = bus.ram_en_out ? rd_q : 8'd0;

    int if_cnt = 0, lsu_cnt = 0, en_cnt = 0;
    always @(negedge clk) begin
        if (bus.if_done_out)  if_cnt++;
        if (bus.lsu_done_out) lsu_cnt++;
        if (bus.ram_en_out)   en_cnt++;
    end

    int pass_cnt = 0, total_cnt = 0, fail_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic lsu_op(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata, output int edges, output logic [31:0] rdata);
        bus.lsu_wr_in = wr; bus.lsu_size_in = size; bus.lsu_addr_in = addr;
        bus.lsu_wdata_in = wdata; bus.lsu_valid_in = 1'b1;
        edges = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); edges++;
            @(negedge clk);
            if (bus.lsu_done_out) break;
        end
        rdata = bus.lsu_rdata_out;
        bus.lsu_valid_in = 1'b0;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic if_op(input logic [31:0] addr, output int edges, output logic [31:0] rdata);
        bus.if_addr_in = addr; bus.if_valid_in = 1'b1;
        edges = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); edges++;
            @(negedge clk);
            if (bus.if_done_out) break;
        end
        rdata = bus.if_data_out;
        bus.if_valid_in = 1'b0;
        @(posedge clk); @(negedge clk);
    endtask

    // Raises both valids together (LSU byte store, IF fetch) and reports completion order.
    task automatic both_op(input logic [31:0] laddr, input logic [7:0] ldata, input logic [31:0] iaddr,
                           output int first, output int second, output logic [31:0] ifd);
        int idx;
        idx = 0; first = 0; second = 0; ifd = 32'd0;
        bus.lsu_wr_in = 1'b1; bus.lsu_size_in = 2'b00; bus.lsu_addr_in = laddr;
        bus.lsu_wdata_in = {24'd0, ldata}; bus.if_addr_in = iaddr;
        bus.lsu_valid_in = 1'b1; bus.if_valid_in = 1'b1;
        for (int k = 0; k < 40 && idx < 2; k++) begin
            @(posedge clk); @(negedge clk);
            if (bus.lsu_done_out) begin
                if (idx == 0) first = 1; else second = 1;
                idx++; bus.lsu_valid_in = 1'b0;
            end
            if (bus.if_done_out) begin
                if (idx == 0) first = 2; else second = 2;
                idx++; ifd = bus.if_data_out; bus.if_valid_in = 1'b0;
            end
        end
        bus.lsu_valid_in = 1'b0; bus.if_valid_in = 1'b0;
        @(posedge clk); @(negedge clk);
    endtask

    initial begin
        int e, f, s, c0, c1;
        logic [31:0] d;
        for (int i = 0; i < 131072; i++) mem[i] = 8'd0;
        mem[17'h300] = 8'h01; mem[17'h301] = 8'h02; mem[17'h302] = 8'h03; mem[17'h303] = 8'h04;
        mem[17'h1FFFF] = 8'h34; mem[17'h00000] = 8'h12;
        for (int i = 0; i < 4; i++) mem[17'h200 + i] = 8'h11;
        bus.if_valid_in = 1'b0; bus.if_addr_in = 32'd0;
        bus.lsu_valid_in = 1'b0; bus.lsu_wr_in = 1'b0; bus.lsu_size_in = 2'b00;
        bus.lsu_addr_in = 32'd0; bus.lsu_wdata_in = 32'd0;
        repeat (3) @(negedge clk);

        chk("rst_ram_en", {31'd0, bus.ram_en_out}, 32'd0);
        chk("rst_ram_rnw", {31'd0, bus.ram_r_nw_out}, 32'd1);
        chk("rst_ram_a", {15'd0, bus.ram_a_out}, 32'd0);
        chk("rst_ram_d", {24'd0, bus.ram_d_out}, 32'd0);
        chk("rst_dones", {30'd0, bus.if_done_out, bus.lsu_done_out}, 32'd0);
        chk("rst_if_data", bus.if_data_out, 32'd0);
        chk("rst_lsu_rdata", bus.lsu_rdata_out, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Contention straight after reset: LSU, then IF; again LSU then IF.
        both_op(32'h40, 8'h77, 32'h300, f, s, d);
        chk("pair1_first_lsu", f, 1);
        chk("pair1_second_if", s, 2);
        chk("pair1_if_data", d, 32'h04030201);
        chk("pair1_store", {24'd0, mem[17'h40]}, 32'h77);
        both_op(32'h41, 8'h88, 32'h300, f, s, d);
        chk("pair2_first_lsu", f, 1);
        chk("pair2_second_if", s, 2);
        // After an LSU-only grant, contention must favour IF.
        lsu_op(1'b1, 2'b00, 32'h42, 32'h99, e, d);
        both_op(32'h43, 8'hAA, 32'h300, f, s, d);
        chk("pair3_first_if", f, 2);
        chk("pair3_second_lsu", s, 1);

        // Word store burst.
        wa.delete(); wd.delete(); wc.delete();
        c0 = lsu_cnt; c1 = en_cnt;
        lsu_op(1'b1, 2'b10, 32'h100, 32'hA1B2C3D4, e, d);
        chk("st4_edges", e, 5);
        chk("st4_done_pulses", lsu_cnt - c0, 1);
        chk("st4_en_cycles", en_cnt - c1, 4);
        chk("st4_nwrites", wa.size(), 4);
        if (wa.size() == 4) begin
            chk("st4_a0", {15'd0, wa[0]}, 32'h100);
            chk("st4_a3", {15'd0, wa[3]}, 32'h103);
            chk("st4_bytes", {wd[3], wd[2], wd[1], wd[0]}, 32'hA1B2C3D4);
            chk("st4_consecutive", wc[3] - wc[0], 3);
        end

        // Word fetch of the stored data, including trailing capture cycle.
        c0 = en_cnt;
        if_op(32'h100, e, d);
        chk("if4_data", d, 32'hA1B2C3D4);
        chk("if4_edges", e, 6);
        chk("if4_en_cycles", en_cnt - c0, 5);

        // Half load wrapping at top of RAM.
        lsu_op(1'b0, 2'b01, 32'h0001FFFF, 32'd0, e, d);
        chk("ld2_wrap_data", d, 32'h00001234);
        chk("ld2_edges", e, 4);

        // Byte store then byte load, IF untouched.
        c0 = if_cnt;
        lsu_op(1'b1, 2'b00, 32'h20, 32'hAABBCC55, e, d);
        chk("st1_edges", e, 2);
        chk("st1_neighbour", {24'd0, mem[17'h21]}, 32'h0);
        lsu_op(1'b0, 2'b00, 32'h20, 32'd0, e, d);
        chk("ld1_data", d, 32'h00000055);
        chk("ld1_edges", e, 3);
        chk("ld1_no_if_done", if_cnt - c0, 0);

        // Reset during byte 2 of a word store.
        c0 = lsu_cnt;
        bus.lsu_wr_in = 1'b1; bus.lsu_size_in = 2'b10; bus.lsu_addr_in = 32'h200;
        bus.lsu_wdata_in = 32'hDEADBEEF; bus.lsu_valid_in = 1'b1;
        @(posedge clk); @(posedge clk); @(posedge clk); #1;
        chk("rstmid_byte2_addr", {15'd0, bus.ram_a_out}, 32'h202);
        rst_n = 1'b0; #1;
        chk("rstmid_en_drop", {31'd0, bus.ram_en_out}, 32'd0);
        bus.lsu_valid_in = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstmid_no_done", lsu_cnt - c0, 0);
        chk("rstmid_mem", {mem[17'h203], mem[17'h202], mem[17'h201], mem[17'h200]}, 32'h1111BEEF);
        lsu_op(1'b0, 2'b00, 32'h201, 32'd0, e, d);
        chk("rstmid_idle_ld", d, 32'h000000BE);
        chk("rstmid_idle_edges", e, 3);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the byte-wide, single-port, synchronous-read on-board RAM, and shares it between the instruction-fetch unit (IF) and the load/store unit (LSU).
- Converts each 1-, 2- or 4-byte little-endian request into a burst of single-byte RAM accesses.
- Sits between the CPU core and the RAM instance; owns all RAM control pins.

Parameters:
ADDR_WIDTH, 17, RAM address width; request addresses are truncated to the low ADDR_WIDTH bits.

Ports:
clk_in  input  1  system clock, rising edge
rst_n_in  input  1  asynchronous active-low reset
if_valid_in  input  1  IF read request; held with address stable until if_done_out
if_addr_in  input  32  IF byte address; always a 4-byte read
if_done_out  output  1  one-cycle pulse; if_data_out valid in the same cycle
if_data_out  output  32  fetched word
lsu_valid_in  input  1  LSU request; held stable until lsu_done_out
lsu_wr_in  input  1  1 = store, 0 = load
lsu_size_in  input  2  00 = byte, 01 = half, 10 = word, 11 = word
lsu_addr_in  input  32  byte address; misalignment permitted
lsu_wdata_in  input  32  store data; low bytes used first
lsu_done_out  output  1  one-cycle completion pulse
lsu_rdata_out  output  32  load data, zero-extended
ram_en_out  output  1  RAM chip enable
ram_r_nw_out  output  1  1 = read, 0 = write
ram_a_out  output  ADDR_WIDTH  RAM byte address
ram_d_out  output  8  RAM write data
ram_d_in  input  8  RAM read data; 0 whenever ram_en_out = 0

Behaviour:
- Reset (asynchronous, immediate):
  - State is IDLE; all outputs are 0 (ram_r_nw_out = 1); priority favours LSU.
  - An in-flight burst is abandoned without a done pulse; a partially written store may remain in RAM.
- FSM states:
  - IDLE: ram_en_out = 0.
  - ACCESS.
  - DONE: lasts one cycle, then returns to IDLE. valid is not sampled in DONE.
- Arbitration at edge E0 (state IDLE, at least one valid = 1):
  - If only one requester is valid, grant it.
  - If both are valid, round-robin: grant the requester not granted last.
  - At E0, latch owner, address, byte count n (1/2/4; IF always 4), write flag and wdata; go to ACCESS.
- Byte timing: byte i is presented between edges Ei and E(i+1).
  - ram_a_out = (addr + i) mod 2^ADDR_WIDTH, so addresses wrap at the top of RAM.
  - ram_en_out = 1 while the byte is presented.
- Write burst:
  - ram_r_nw_out = 0 and ram_d_out = wdata[8i+7:8i].
  - RAM writes byte i at E(i+1).
  - Go to DONE at En; done is high between En and E(n+1).
  - Total latency is n+1 edges from E0 to the done cycle.
- Read burst:
  - ram_r_nw_out = 1.
  - Byte i is captured from ram_d_in at E(i+2) into rdata[8i+7:8i].
  - One trailing capture cycle (En to E(n+1)) keeps ram_en_out = 1, ram_r_nw_out = 1 and ram_a_out at the last byte address. This is required because the RAM gates its output with enable.
  - Go to DONE at E(n+1); done is high between E(n+1) and E(n+2).
  - A 4-byte read has done 6 edges after E0.
- Read data:
  - Unused upper bytes are 0.
  - Data outputs hold their value until the same requester's next done.
  - The done pulse goes only to the owner; the other requester's done stays 0.
- Requester obligations:
  - Hold inputs stable while valid and not done.
  - Deasserting valid mid-burst does not abort the burst.
  - A valid still high in the IDLE cycle after DONE is treated as a new request.
- No bubble beyond DONE: back-to-back requests are accepted every n+2 (write) or n+3 (read) cycles.
- ram_d_out = 0 except during write bytes.

Test Plan:
- LSU word store, addr 0x100, wdata 0xA1B2C3D4 -> RAM writes 0xD4, C3, B2, A1 at 0x100..0x103 on consecutive cycles with r_nw = 0; lsu_done_out pulses once, 5 edges after acceptance.
- IF fetch from 0x100 after that store -> if_data_out = 0xA1B2C3D4 with the done pulse 6 edges after acceptance; ram_en_out stays high through the trailing capture cycle.
- Simultaneous IF and LSU valid directly after reset -> LSU is served first, then IF; a second simultaneous pair is served LSU then IF again (round-robin alternation holds).
- LSU half load at 0x1FFFF, RAM[0x1FFFF] = 0x34, RAM[0x00000] = 0x12 -> address wraps to 0; lsu_rdata_out = 0x00001234.
- LSU byte store 0x55 to 0x20, then byte load from 0x20 -> load returns 0x00000055; if_done_out stays 0 throughout.
- Assert rst_n_in low during the third byte of a word store -> ram_en_out drops in the same cycle and no done pulse occurs; after release the FSM is IDLE, bytes 0-1 are written and bytes 2-3 are unchanged.
